// File: rtl/snake_score_pkg.sv
// Shared types and constants for the snake score keeper.
package snake_score_pkg;

    typedef struct packed {
        logic [1:0] huns;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_score_t;

    localparam logic [9:0] SCORE_MAX = 10'h399;

    typedef enum logic {
        PLAY,
        OVER
    } score_state_t;

endpackage

// File: rtl/bcd_digit_inc.sv
// One BCD digit incrementer stage; wraps to zero and carries at max_digit.
module bcd_digit_inc (
    input  logic [3:0] digit,
    input  logic       carry_in,
    input  logic [3:0] max_digit,
    output logic [3:0] digit_next,
    output logic       carry_out
);

    always_comb begin
        digit_next = digit;
        carry_out  = 1'b0;
        if (carry_in) begin
            if (digit == max_digit) begin
                digit_next = 4'd0;
                carry_out  = 1'b1;
            end else begin
                digit_next = digit + 4'd1;
            end
        end
    end

endmodule

// File: rtl/snake_score_counter.sv
// Packed-BCD score keeper: live counter, frame-synchronised display word and
// session high score for the VGA score overlay.
module snake_score_counter
    import snake_score_pkg::*;
#(
    parameter int unsigned HUNS_MAX = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       eat,
    input  logic       game_over,
    input  logic       game_restart,
    input  logic       frame_start,
    output logic [9:0] score,
    output logic [9:0] high_score,
    output logic       new_high,
    output logic       saturated
);

    score_state_t state_q, state_d;
    bcd_score_t   live_q, live_d, live_inc;
    bcd_score_t   score_q, high_q;
    logic         new_high_q, new_high_d;
    logic         inc_en, ones_carry, tens_carry, high_update;
    logic [3:0]   huns_next;
    logic         huns_carry;
    logic         unused_huns;

    assign saturated = (live_q == SCORE_MAX);
    assign inc_en    = eat && (state_q == PLAY) && !saturated && !game_restart;

    bcd_digit_inc u_ones (
        .digit      (live_q.ones),
        .carry_in   (inc_en),
        .max_digit  (4'd9),
        .digit_next (live_inc.ones),
        .carry_out  (ones_carry)
    );

    bcd_digit_inc u_tens (
        .digit      (live_q.tens),
        .carry_in   (ones_carry),
        .max_digit  (4'd9),
        .digit_next (live_inc.tens),
        .carry_out  (tens_carry)
    );

    // Saturation gating means the hundreds stage never sees a carry at HUNS_MAX.
    bcd_digit_inc u_huns (
        .digit      ({2'b00, live_q.huns}),
        .carry_in   (tens_carry),
        .max_digit  (4'(HUNS_MAX)),
        .digit_next (huns_next),
        .carry_out  (huns_carry)
    );

    assign live_inc.huns = huns_next[1:0];
    assign unused_huns   = ^{huns_next[3:2], huns_carry};

    always_comb begin
        state_d = state_q;
        live_d  = live_q;
        if (game_restart) begin
            state_d = PLAY;
            live_d  = '0;
        end else begin
            live_d = live_inc;
            if (game_over) begin
                state_d = OVER;
            end
        end
    end

    // Packed BCD ordering matches numeric ordering, so a plain compare works.
    assign high_update = (10'(live_q) > 10'(high_q));

    always_comb begin
        new_high_d = new_high_q;
        if (game_restart) begin
            new_high_d = 1'b0;
        end else if (high_update) begin
            new_high_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PLAY;
            live_q     <= '0;
            score_q    <= '0;
            high_q     <= '0;
            new_high_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            live_q     <= live_d;
            new_high_q <= new_high_d;
            if (frame_start) begin
                score_q <= live_q;
            end
            if (high_update) begin
                high_q <= live_q;
            end
        end
    end

    assign score      = score_q;
    assign high_score = high_q;
    assign new_high   = new_high_q;

endmodule

// File: tb/tb_snake_score_counter.sv
// Directed bench for snake_score_counter: vector table plus multi-cycle sequences.
module tb_snake_score_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       eat = 1'b0;
    logic       game_over = 1'b0;
    logic       game_restart = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] score;
    logic [9:0] high_score;
    logic       new_high;
    logic       saturated;

    int n_tests = 0;
    int n_fail  = 0;

    snake_score_counter #(.HUNS_MAX(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .eat          (eat),
        .game_over    (game_over),
        .game_restart (game_restart),
        .frame_start  (frame_start),
        .score        (score),
        .high_score   (high_score),
        .new_high     (new_high),
        .saturated    (saturated)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       e;
        logic       go;
        logic       gr;
        logic       fs;
        logic [9:0] exp_score;
        logic [9:0] exp_high;
        logic       exp_nh;
        logic       exp_sat;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%03h, expected 0x%03h", name, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic go, input logic gr, input logic fs);
        @(negedge clk);
        eat = e;
        game_over = go;
        game_restart = gr;
        frame_start = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic eat_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        eat = 1'b0;
        game_over = 1'b0;
        game_restart = 1'b0;
        frame_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        //            eat  go   gr   fs    score   high    nh   sat
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10'h001, 10'h001, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h001, 10'h001, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 10'h002, 10'h002, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h002, 10'h003, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10'h003, 10'h003, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h003, 10'h003, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h003, 10'h004, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10'h004, 10'h004, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10'h004, 10'h004, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 10'h004, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h004, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 10'h004, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h004, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 10'h001, 10'h004, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'h002, 10'h004, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_score", score, 10'h000);
        check("reset_high", high_score, 10'h000);
        check("reset_new_high", {9'd0, new_high}, 10'd0);
        check("reset_sat", {9'd0, saturated}, 10'd0);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].e, vecs[i].go, vecs[i].gr, vecs[i].fs);
            check($sformatf("vec%0d_score", i), score, vecs[i].exp_score);
            check($sformatf("vec%0d_high", i), high_score, vecs[i].exp_high);
            check($sformatf("vec%0d_new_high", i), {9'd0, new_high}, {9'd0, vecs[i].exp_nh});
            check($sformatf("vec%0d_sat", i), {9'd0, saturated}, {9'd0, vecs[i].exp_sat});
        end

        // Ones/tens carry chain.
        do_reset();
        eat_n(10);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("carry_010", score, 10'h010);
        eat_n(99);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("carry_109", score, 10'h109);
        check("carry_109_high", high_score, 10'h109);

        // Saturation at 399.
        do_reset();
        eat_n(420);
        check("sat_flag", {9'd0, saturated}, 10'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_score", score, 10'h399);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_hold_score", score, 10'h399);
        check("sat_hold_flag", {9'd0, saturated}, 10'd1);
        check("sat_high", high_score, 10'h399);

        // Game over freezes counting; restart clears live but keeps high score.
        do_reset();
        eat_n(25);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        eat_n(5);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("over_score", score, 10'h025);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("restart_score_holds", score, 10'h025);
        eat_n(3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        check("restart_score", score, 10'h003);
        check("restart_high", high_score, 10'h025);
        check("restart_new_high", {9'd0, new_high}, 10'd0);

        // eat and frame_start together: display gets pre-increment value.
        do_reset();
        eat_n(7);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("eat_frame_score", score, 10'h007);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("eat_frame_next", score, 10'h008);

        // eat with restart is dropped.
        do_reset();
        eat_n(50);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("eat_restart_score", score, 10'h000);
        check("eat_restart_high", high_score, 10'h050);

        // Asynchronous reset between clock edges.
        do_reset();
        eat_n(5);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        check("pre_async_score", score, 10'h005);
        check("pre_async_new_high", {9'd0, new_high}, 10'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_score", score, 10'h000);
        check("async_high", high_score, 10'h000);
        check("async_new_high", {9'd0, new_high}, 10'd0);
        check("async_sat", {9'd0, saturated}, 10'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_score_counter.md
# snake_score_counter

Game-side score keeper for the snake VGA design: counts food-eaten events in packed BCD, tracks a session high score, and presents a frame-stable score word to the VGA score-overlay stage, which draws it as three seven-segment digits. The displayed value changes only on a frame boundary, so a digit never tears mid-frame. Sits between the game-logic FSM (eat / game-over / restart pulses) and the VGA score renderer.

## Interface

Parameters:
- HUNS_MAX, 3, largest hundreds digit; fixed by the 2-bit hundreds field, so values above 3 are illegal.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- eat  input  1  single-cycle pulse; snake consumed food.
- game_over  input  1  single-cycle pulse; freezes counting.
- game_restart  input  1  single-cycle pulse; clears live score, resumes counting.
- frame_start  input  1  single-cycle pulse at start of vertical blanking.
- score  output  10  display score, packed BCD {huns[1:0], tens[3:0], ones[3:0]}.
- high_score  output  10  session high score, same packing; not frame-synchronised.
- new_high  output  1  live score exceeded high_score during the current game.
- saturated  output  1  live score is at maximum (399).

## Operation

- FSM states: PLAY and OVER. Reset enters PLAY.
  - PLAY → OVER on game_over.
  - Any state → PLAY on game_restart, with live cleared to 000.
  - game_restart wins over game_over in the same cycle.
- Live counter (internal) increments by 1 on eat only in PLAY and only when not saturated.
- BCD increment rules:
  - ones 9→0 carries into tens; tens 9→0 carries into hundreds.
  - Hundreds never wraps. At 399 the counter holds, eat is ignored, and saturated=1.
- eat coinciding with game_restart is dropped: live becomes 000.
- eat coinciding with game_over is counted: the transition takes effect after this cycle's increment.
- Display register: score loads live on frame_start. live is sampled pre-increment, so an eat in the same cycle shows on the next frame.
- High score:
  - high_score updates whenever live > high_score.
  - Compare as an unsigned 10-bit value; packed BCD order equals numeric order.
  - high_score survives game_restart and is cleared only by reset.
- new_high sets in the cycle high_score updates and clears on game_restart.
- Reset values: score=0, high_score=0, new_high=0, saturated=0, live=0, state=PLAY.
- Illegal BCD digits (>9) never arise from legal operation. No recovery logic is required.

## Timing

- eat at edge N → live updated after N. saturated reflects live after N.
- high_score and new_high update one cycle after live exceeds high_score (registered compare), i.e. after edge N+1.
- frame_start at edge M → score equals the pre-edge-M live value after M. It holds until the next frame_start.
- Back-to-back eat pulses on consecutive cycles each count; no pulse is lost.
- game_restart at edge R → live=0 after R. score shows 000 only after the next frame_start.
- Asynchronous reset mid-frame clears every output immediately, independent of clk.

## Structure

- Package snake_score_pkg holds:
  - typedef bcd_score_t, a packed struct {logic [1:0] huns; logic [3:0] tens; logic [3:0] ones;}.
  - constant SCORE_MAX = 10'h399.
  - enum score_state_t {PLAY, OVER}.
- Offset and geometry constants stay in the existing VGA params include; this block needs none.
- One sub-module, bcd_digit_inc: inputs digit, carry_in, max_digit; outputs digit_next, carry_out. Instantiated three times in a ripple chain.
- Everything else is flat in snake_score_counter.

## Test plan

- Reset, then 1 eat and 1 frame_start → score=0x001, high_score=0x001, new_high=1.
- 10 eats then frame_start → score=0x010. After 109 total eats → 0x109, tens/ones carry chain verified.
- 420 eats → live holds 0x399 and saturated=1. Further eat leaves score at 0x399 after frame_start.
- 25 eats, game_over, 5 eats, frame_start → score=0x025. game_restart, 3 eats, frame_start → score=0x003, high_score=0x025, new_high=0.
- eat and frame_start in the same cycle with live=0x007 → score=0x007 after that edge, 0x008 after the next frame_start.
- eat and game_restart in the same cycle with live=0x050 → live=0x000. Asynchronous reset asserted between clock edges → all outputs 0 before the next edge.
